// File: rtl/multicycle_control_unit.sv
// Multicycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB for a small
// RV32-style core, traps on illegal opcodes or a stuck data memory, and
// counts retired instructions.
module multicycle_control_unit #(
    parameter int MEM_TIMEOUT = 8,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic [6:0]       op,
    input  logic             mem_ready,
    input  logic             stall,
    output logic             fetch_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             jump,
    output logic             branch,
    output logic             instr_done,
    output logic             illegal,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    // Opcode encodings shared with the rest of the core (RV32 base opcodes).
    localparam logic [6:0] OP_R_TYPE  = 7'b0110011;
    localparam logic [6:0] OP_I_IMM   = 7'b0010011;
    localparam logic [6:0] OP_I_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_S_TYPE  = 7'b0100011;
    localparam logic [6:0] OP_B_TYPE  = 7'b1100011;
    localparam logic [6:0] OP_J_JAL   = 7'b1101111;
    localparam logic [6:0] OP_I_JALR  = 7'b1100111;
    localparam logic [6:0] OP_U_LUI   = 7'b0110111;
    localparam logic [6:0] OP_U_AUIPC = 7'b0010111;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    // The wait counter never needs to exceed MEM_TIMEOUT-1 when the timeout is on.
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    logic [2:0]        state_next;
    logic [6:0]        op_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              op_legal;
    logic              is_load;
    logic              is_store;
    logic              is_branch;
    logic              is_jump;
    logic              wait_expired;

    assign is_load      = (op_q == OP_I_LOAD);
    assign is_store     = (op_q == OP_S_TYPE);
    assign is_branch    = (op_q == OP_B_TYPE);
    assign is_jump      = (op_q == OP_J_JAL) || (op_q == OP_I_JALR);
    assign wait_expired = (MEM_TIMEOUT > 0) && (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

    // Classify the latched opcode as legal or illegal.
    always_comb begin
        op_legal = 1'b0;
        case (op_q)
            OP_R_TYPE, OP_I_IMM, OP_I_LOAD, OP_S_TYPE, OP_B_TYPE,
            OP_J_JAL, OP_I_JALR, OP_U_LUI, OP_U_AUIPC: op_legal = 1'b1;
            default:                                   op_legal = 1'b0;
        endcase
    end

    // Next-state selection; stall is applied at the register, not here.
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:  if (instr_valid) state_next = S_DECODE;
            S_DECODE: state_next = op_legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (is_load || is_store) state_next = S_MEM;
                else if (is_branch)      state_next = S_FETCH;
                else                     state_next = S_WB;
            end
            S_MEM: begin
                if (mem_ready)         state_next = is_load ? S_WB : S_FETCH;
                else if (wait_expired) state_next = S_TRAP;
            end
            S_WB:     state_next = S_FETCH;
            S_TRAP:   state_next = S_TRAP;
            default:  state_next = S_FETCH;
        endcase
    end

    // Control outputs decoded from state and latched opcode; stall forces them low.
    always_comb begin
        fetch_req  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        jump       = 1'b0;
        branch     = 1'b0;
        instr_done = 1'b0;
        illegal    = (state == S_TRAP);
        if (!stall) begin
            case (state)
                S_FETCH: begin
                    fetch_req = 1'b1;
                    ir_write  = instr_valid;
                end
                S_EXEC: begin
                    pc_write   = 1'b1;
                    branch     = is_branch;
                    instr_done = is_branch;
                end
                S_MEM: begin
                    mem_read   = is_load;
                    mem_write  = is_store;
                    instr_done = is_store && mem_ready;
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    jump       = is_jump;
                end
                default: ;
            endcase
        end
    end

    // State, opcode latch, memory wait counter and retire counter; all frozen by stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            op_q     <= '0;
            wait_cnt <= '0;
            retired  <= '0;
        end else if (!stall) begin
            state <= state_next;
            if (state == S_FETCH && instr_valid)
                op_q <= op;
            if (state == S_EXEC)
                wait_cnt <= '0;
            else if (state == S_MEM && !mem_ready)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            if (instr_done)
                retired <= retired + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit: each instruction is modelled
// as a list of phases derived from its opcode class, walked cycle by cycle
// with random stalls, memory waits, idle fetches and resets.
module tb_multicycle_control_unit;

    localparam int MEM_TIMEOUT = 8;
    localparam int CNT_W       = 4;
    localparam int NUM_INSTR   = 300;

    localparam int PH_F = 0;
    localparam int PH_D = 1;
    localparam int PH_E = 2;
    localparam int PH_M = 3;
    localparam int PH_W = 4;
    localparam int PH_T = 5;

    localparam logic [6:0] OP_R_TYPE  = 7'b0110011;
    localparam logic [6:0] OP_I_IMM   = 7'b0010011;
    localparam logic [6:0] OP_I_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_S_TYPE  = 7'b0100011;
    localparam logic [6:0] OP_B_TYPE  = 7'b1100011;
    localparam logic [6:0] OP_J_JAL   = 7'b1101111;
    localparam logic [6:0] OP_I_JALR  = 7'b1100111;
    localparam logic [6:0] OP_U_LUI   = 7'b0110111;
    localparam logic [6:0] OP_U_AUIPC = 7'b0010111;

    logic clk = 1'b0;
    logic rst;
    logic instr_valid;
    logic [6:0] op;
    logic mem_ready;
    logic stall;
    logic fetch_req, ir_write, pc_write, mem_read, mem_write;
    logic reg_write, jump, branch, instr_done, illegal;
    logic [2:0] state;
    logic [CNT_W-1:0] retired;

    logic [6:0] legal_ops [9] = '{OP_R_TYPE, OP_I_IMM, OP_I_LOAD, OP_S_TYPE, OP_B_TYPE,
                                  OP_J_JAL, OP_I_JALR, OP_U_LUI, OP_U_AUIPC};
    int wait_choices [8] = '{0, 0, 1, 2, 3, 7, 8, 11};

    int vectors     = 0;
    int miscompares = 0;
    int exp_retired = 0;

    multicycle_control_unit #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .instr_valid(instr_valid),
        .op         (op),
        .mem_ready  (mem_ready),
        .stall      (stall),
        .fetch_req  (fetch_req),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .jump       (jump),
        .branch     (branch),
        .instr_done (instr_done),
        .illegal    (illegal),
        .state      (state),
        .retired    (retired)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic bit isLegal(input logic [6:0] o);
        foreach (legal_ops[i])
            if (legal_ops[i] == o) return 1'b1;
        return 1'b0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Drive one cycle, check outputs against the phase model, advance the clock.
    task automatic applyStimulus(input int ph, input logic [6:0] iop, input logic s,
                                 input logic iv, input logic mr, input logic [6:0] dop);
        logic e_fetch, e_ir, e_pc, e_mr, e_mw, e_rw, e_j, e_br, e_done, e_ill;
        stall       = s;
        instr_valid = iv;
        mem_ready   = mr;
        op          = dop;
        #1;
        {e_fetch, e_ir, e_pc, e_mr, e_mw, e_rw, e_j, e_br, e_done} = '0;
        e_ill = (ph == PH_T);
        if (!s) begin
            case (ph)
                PH_F: begin e_fetch = 1'b1; e_ir = iv; end
                PH_E: begin e_pc = 1'b1; e_br = (iop == OP_B_TYPE); e_done = (iop == OP_B_TYPE); end
                PH_M: begin
                    e_mr   = (iop == OP_I_LOAD);
                    e_mw   = (iop == OP_S_TYPE);
                    e_done = (iop == OP_S_TYPE) && mr;
                end
                PH_W: begin
                    e_rw = 1'b1; e_done = 1'b1;
                    e_j  = (iop == OP_J_JAL) || (iop == OP_I_JALR);
                end
                default: ;
            endcase
        end
        checkOutput("state", 32'(state), 32'(ph));
        checkOutput("ctrl", 32'({fetch_req, ir_write, pc_write, mem_read, mem_write,
                                 reg_write, jump, branch, instr_done, illegal}),
                    32'({e_fetch, e_ir, e_pc, e_mr, e_mw, e_rw, e_j, e_br, e_done, e_ill}));
        checkOutput("retired", 32'(retired), 32'(exp_retired));
        @(posedge clk);
        if (e_done) exp_retired = (exp_retired + 1) % (1 << CNT_W);
        @(negedge clk);
    endtask

    // Synchronous reset pulse with random other inputs, including stall.
    task automatic resetDut();
        rst         = 1'b1;
        stall       = 1'($urandom_range(0, 1));
        instr_valid = 1'($urandom_range(0, 1));
        mem_ready   = 1'($urandom_range(0, 1));
        op          = 7'($urandom_range(0, 127));
        @(posedge clk);
        @(negedge clk);
        rst         = 1'b0;
        exp_retired = 0;
    endtask

    initial begin
        int ph_q[$];
        logic [6:0] cur_op;
        logic s, iv, mr;
        logic [6:0] dop;
        int idx, idle, waits, consec, guard, r;
        bit aborted;

        rst = 1'b1; stall = 1'b0; instr_valid = 1'b0; mem_ready = 1'b0; op = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        $display("[TB] reset released, starting %0d random instructions", NUM_INSTR);

        for (int n = 0; n < NUM_INSTR; n++) begin
            r = $urandom_range(0, 11);
            if (r < 9)       cur_op = legal_ops[r];
            else if (r == 9) cur_op = 7'h7f;
            else             cur_op = 7'($urandom_range(0, 127));

            ph_q.delete();
            ph_q.push_back(PH_F);
            ph_q.push_back(PH_D);
            if (!isLegal(cur_op)) begin
                ph_q.push_back(PH_T);
            end else begin
                ph_q.push_back(PH_E);
                if (cur_op == OP_I_LOAD)      begin ph_q.push_back(PH_M); ph_q.push_back(PH_W); end
                else if (cur_op == OP_S_TYPE) ph_q.push_back(PH_M);
                else if (cur_op != OP_B_TYPE) ph_q.push_back(PH_W);
            end

            waits   = wait_choices[$urandom_range(0, 7)];
            idle    = $urandom_range(0, 2);
            consec  = 0;
            idx     = 0;
            guard   = 0;
            aborted = 1'b0;

            while (idx < ph_q.size() && !aborted) begin
                guard++;
                if (guard > 200) begin
                    miscompares++;
                    $display("[TB] FAIL cycle_budget: got %0d cycles, expected at most 200", guard);
                    aborted = 1'b1;
                end else if (ph_q[idx] == PH_T) begin
                    for (int k = 0; k < int'($urandom_range(2, 5)); k++)
                        applyStimulus(PH_T, cur_op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                      1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)));
                    resetDut();
                    aborted = 1'b1;
                end else if ($urandom_range(0, 80) == 0) begin
                    resetDut();
                    aborted = 1'b1;
                end else begin
                    s   = ($urandom_range(0, 4) == 0);
                    iv  = 1'($urandom_range(0, 1));
                    mr  = 1'($urandom_range(0, 1));
                    dop = 7'($urandom_range(0, 127));
                    if (!s) begin
                        if (ph_q[idx] == PH_F) begin
                            iv = (idle == 0);
                            if (iv) dop = cur_op;
                        end else if (ph_q[idx] == PH_M) begin
                            mr = (waits == 0);
                        end
                    end
                    applyStimulus(ph_q[idx], cur_op, s, iv, mr, dop);
                    if (!s) begin
                        case (ph_q[idx])
                            PH_F: if (iv) idx++; else idle--;
                            PH_M: begin
                                if (mr) idx++;
                                else begin
                                    waits--;
                                    consec++;
                                    if (consec == MEM_TIMEOUT) begin
                                        ph_q.delete();
                                        ph_q.push_back(PH_T);
                                        idx = 0;
                                    end
                                end
                            end
                            default: idx++;
                        endcase
                    end
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
